// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the RV32I memory stage:
//   - opcode width and the LOAD / STORE major opcodes
//   - funct3 size/sign encodings for loads and stores
//   - memory-stage FSM state encoding
//   - helpers that decode access size and misalignment from funct3 + lane
// -----------------------------------------------------------------------------
package mem_access_pkg;

    localparam int OPCODE_WIDTH = 7;

    localparam logic [OPCODE_WIDTH-1:0] LOAD_WORD  = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] STORE_WORD = 7'b0100011;

    // funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } me_state_t;

    // Access size in bytes (1, 2 or 4). Any funct3 outside the defined
    // byte/half encodings is a full-word access.
    function automatic logic [2:0] access_bytes(input logic is_store,
                                                input logic [2:0] funct3);
        logic [2:0] bytes;
        bytes = 3'd4;
        if (is_store) begin
            if (funct3 == F3_SB)      bytes = 3'd1;
            else if (funct3 == F3_SH) bytes = 3'd2;
        end else begin
            if (funct3 == F3_LB || funct3 == F3_LBU)      bytes = 3'd1;
            else if (funct3 == F3_LH || funct3 == F3_LHU) bytes = 3'd2;
        end
        return bytes;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] bytes,
                                           input logic [1:0] lane);
        return ((bytes == 3'd2) && lane[0]) || ((bytes == 3'd4) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// -----------------------------------------------------------------------------
// mem_access_load_align
// Combinational load formatter: selects the addressed byte/half lane of the
// returned bus word and sign- or zero-extends it according to funct3.
// Ports:
//   i_rdata  : raw word returned by the data bus
//   i_lane   : byte offset (address bits [1:0]) captured when the load started
//   i_funct3 : load size/sign encoding
//   o_value  : formatted value for the destination register
// -----------------------------------------------------------------------------
module mem_access_load_align
    import mem_access_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int FUNCT_WIDTH = 3
) (
    input  logic [DWIDTH-1:0]      i_rdata,
    input  logic [1:0]             i_lane,
    input  logic [FUNCT_WIDTH-1:0] i_funct3,
    output logic [DWIDTH-1:0]      o_value
);

    logic [DWIDTH-1:0] w_shifted;

    // Move the addressed lane down to bit 0 so one extension path serves all lanes.
    assign w_shifted = i_rdata >> {i_lane, 3'b000};

    always_comb begin
        o_value = i_rdata;
        case (i_funct3)
            F3_LB:   o_value = {{(DWIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
            F3_LBU:  o_value = {{(DWIDTH-8){1'b0}}, w_shifted[7:0]};
            F3_LH:   o_value = {{(DWIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
            F3_LHU:  o_value = {{(DWIDTH-16){1'b0}}, w_shifted[15:0]};
            default: o_value = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
// Memory stage of the 5-stage RV32I pipeline. Loads and stores become single
// pipelined-Wishbone transactions; everything else is registered straight
// through to writeback with one cycle of latency.
// Ports:
//   me_clk / me_rst          : clock, asynchronous active-low reset
//   me_i_*  (execute side)   : opcode, funct3, effective address, store data,
//                              rd address/data, write enable, valid
//   me_i_ce/stall/flush      : stage enable, writeback stall, flush request
//   me_o_stall               : holds upstream while a bus access is in flight
//   me_o_flush / me_o_ce     : registered flush copy and enable to writeback
//   me_o_wb_* / me_i_wb_*    : pipelined Wishbone master
//   me_o_* (writeback side)  : opcode, funct3, rd address/data, we, valid,
//                              misaligned flag
//   me_o_dbg_state           : current FSM state (debug visibility)
//
// Bus handshake: stb is a request that the slave takes on any edge where
// stb=1 and wb_stall=0; the request is then withdrawn. cyc stays high until
// the edge on which ack=1 is sampled, which also registers the result.
// -----------------------------------------------------------------------------
module mem_access
    import mem_access_pkg::*;
#(
    parameter int AWIDTH      = 5,
    parameter int DWIDTH      = 32,
    parameter int FUNCT_WIDTH = 3
) (
    input  logic                    me_clk,
    input  logic                    me_rst,
    input  logic [OPCODE_WIDTH-1:0] me_i_opcode,
    input  logic [FUNCT_WIDTH-1:0]  me_i_funct3,
    input  logic [DWIDTH-1:0]       me_i_alu_value,
    input  logic [DWIDTH-1:0]       me_i_data_rs2,
    input  logic [AWIDTH-1:0]       me_i_addr_rd,
    input  logic [DWIDTH-1:0]       me_i_data_rd,
    input  logic                    me_i_we_reg,
    input  logic                    me_i_valid,
    input  logic                    me_i_ce,
    input  logic                    me_i_stall,
    input  logic                    me_i_flush,
    output logic                    me_o_stall,
    output logic                    me_o_flush,
    output logic                    me_o_ce,
    output logic                    me_o_wb_cyc,
    output logic                    me_o_wb_stb,
    output logic                    me_o_wb_we,
    output logic [DWIDTH-1:0]       me_o_wb_addr,
    output logic [DWIDTH-1:0]       me_o_wb_data,
    output logic [3:0]              me_o_wb_sel,
    input  logic                    me_i_wb_ack,
    input  logic                    me_i_wb_stall,
    input  logic [DWIDTH-1:0]       me_i_wb_data,
    output logic [OPCODE_WIDTH-1:0] me_o_opcode,
    output logic [FUNCT_WIDTH-1:0]  me_o_funct3,
    output logic [AWIDTH-1:0]       me_o_addr_rd,
    output logic [DWIDTH-1:0]       me_o_data_rd,
    output logic                    me_o_we_reg,
    output logic                    me_o_valid,
    output logic                    me_o_misaligned,
    output logic [1:0]              me_o_dbg_state
);

    me_state_t               r_state;
    logic                    r_cyc;
    logic                    r_stb;
    logic                    r_we;
    logic [DWIDTH-1:0]       r_addr;
    logic [DWIDTH-1:0]       r_wdata;
    logic [3:0]              r_sel;
    logic [1:0]              r_lane;
    logic                    r_flush_pend;
    logic [OPCODE_WIDTH-1:0] r_opcode;
    logic [FUNCT_WIDTH-1:0]  r_funct3;
    logic [AWIDTH-1:0]       r_addr_rd;
    logic [DWIDTH-1:0]       r_data_rd;
    logic                    r_we_reg;
    logic                    r_valid;
    logic                    r_misaligned;
    logic                    r_flush;
    logic                    r_ce;

    logic                    w_is_load;
    logic                    w_is_store;
    logic [1:0]              w_lane;
    logic [2:0]              w_bytes;
    logic                    w_misaligned;
    logic [3:0]              w_sel;
    logic [DWIDTH-1:0]       w_wdata;
    logic                    w_stall;
    logic                    w_done;
    logic                    w_drop;
    logic [DWIDTH-1:0]       w_load_value;

    assign w_is_load    = (me_i_opcode == LOAD_WORD);
    assign w_is_store   = (me_i_opcode == STORE_WORD);
    assign w_lane       = me_i_alu_value[1:0];
    assign w_bytes      = access_bytes(w_is_store, me_i_funct3[2:0]);
    assign w_misaligned = is_misaligned(w_bytes, w_lane);
    assign w_stall      = (r_state != ST_IDLE);

    // Byte enables and lane-replicated store data; loads always read the
    // whole word and are formatted on return.
    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = me_i_data_rs2;
        if (w_is_store) begin
            case (w_bytes)
                3'd1: begin
                    w_sel   = 4'b0001 << w_lane;
                    w_wdata = {4{me_i_data_rs2[7:0]}};
                end
                3'd2: begin
                    w_sel   = 4'b0011 << w_lane;
                    w_wdata = {2{me_i_data_rs2[15:0]}};
                end
                default: begin
                    w_sel   = 4'b1111;
                    w_wdata = me_i_data_rs2;
                end
            endcase
        end
    end

    // Completion: an ack counts in REQ only on the edge the request is taken.
    assign w_done = ((r_state == ST_REQ) && !me_i_wb_stall && me_i_wb_ack) ||
                    ((r_state == ST_WAIT) && me_i_wb_ack);
    // A flush seen at any point during the access discards its result.
    assign w_drop = r_flush_pend || me_i_flush;

    mem_access_load_align #(
        .DWIDTH      (DWIDTH),
        .FUNCT_WIDTH (FUNCT_WIDTH)
    ) u_load_align (
        .i_rdata  (me_i_wb_data),
        .i_lane   (r_lane),
        .i_funct3 (r_funct3),
        .o_value  (w_load_value)
    );

    always_ff @(posedge me_clk or negedge me_rst) begin
        if (!me_rst) begin
            r_state      <= ST_IDLE;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_sel        <= '0;
            r_lane       <= '0;
            r_flush_pend <= 1'b0;
            r_opcode     <= '0;
            r_funct3     <= '0;
            r_addr_rd    <= '0;
            r_data_rd    <= '0;
            r_we_reg     <= 1'b0;
            r_valid      <= 1'b0;
            r_misaligned <= 1'b0;
            r_flush      <= 1'b0;
            r_ce         <= 1'b0;
        end else begin
            r_flush <= me_i_flush;
            r_ce    <= me_i_ce && !w_stall && !me_i_flush;

            case (r_state)
                ST_IDLE: begin
                    if (me_i_flush) begin
                        r_opcode     <= '0;
                        r_funct3     <= '0;
                        r_addr_rd    <= '0;
                        r_data_rd    <= '0;
                        r_we_reg     <= 1'b0;
                        r_valid      <= 1'b0;
                        r_misaligned <= 1'b0;
                    end else if (me_i_stall) begin
                        // writeback is stalled: hold the presented result
                    end else if (me_i_ce) begin
                        r_opcode  <= me_i_opcode;
                        r_funct3  <= me_i_funct3;
                        r_addr_rd <= me_i_addr_rd;
                        // Bubbles (valid=0) never start a bus access.
                        if ((w_is_load || w_is_store) && me_i_valid) begin
                            if (w_misaligned) begin
                                r_data_rd    <= me_i_alu_value;
                                r_we_reg     <= 1'b0;
                                r_valid      <= 1'b1;
                                r_misaligned <= 1'b1;
                            end else begin
                                r_cyc        <= 1'b1;
                                r_stb        <= 1'b1;
                                r_we         <= w_is_store;
                                r_addr       <= {me_i_alu_value[DWIDTH-1:2], 2'b00};
                                r_sel        <= w_sel;
                                r_wdata      <= w_wdata;
                                r_lane       <= w_lane;
                                r_flush_pend <= 1'b0;
                                r_we_reg     <= 1'b0;
                                r_valid      <= 1'b0;
                                r_misaligned <= 1'b0;
                                r_state      <= ST_REQ;
                            end
                        end else begin
                            r_data_rd    <= me_i_data_rd;
                            r_we_reg     <= me_i_we_reg;
                            r_valid      <= me_i_valid;
                            r_misaligned <= 1'b0;
                        end
                    end else begin
                        r_we_reg     <= 1'b0;
                        r_valid      <= 1'b0;
                        r_misaligned <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (!me_i_wb_stall) begin
                        r_stb   <= 1'b0;
                        r_state <= w_done ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (me_i_wb_ack) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_stall && me_i_flush) begin
                r_flush_pend <= 1'b1;
            end

            if (w_done) begin
                r_cyc        <= 1'b0;
                r_flush_pend <= 1'b0;
                r_misaligned <= 1'b0;
                if (w_drop) begin
                    r_valid  <= 1'b0;
                    r_we_reg <= 1'b0;
                end else begin
                    r_valid   <= 1'b1;
                    r_we_reg  <= !r_we;
                    r_data_rd <= r_we ? '0 : w_load_value;
                end
            end
        end
    end

    assign me_o_stall      = w_stall;
    assign me_o_flush      = r_flush;
    assign me_o_ce         = r_ce;
    assign me_o_wb_cyc     = r_cyc;
    assign me_o_wb_stb     = r_stb;
    assign me_o_wb_we      = r_we;
    assign me_o_wb_addr    = r_addr;
    assign me_o_wb_data    = r_wdata;
    assign me_o_wb_sel     = r_sel;
    assign me_o_opcode     = r_opcode;
    assign me_o_funct3     = r_funct3;
    assign me_o_addr_rd    = r_addr_rd;
    assign me_o_data_rd    = r_data_rd;
    assign me_o_we_reg     = r_we_reg;
    assign me_o_valid      = r_valid;
    assign me_o_misaligned = r_misaligned;
    assign me_o_dbg_state  = r_state;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT inputs
  logic [6:0]  i_opcode = '0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_alu = '0;
  logic [31:0] i_rs2 = '0;
  logic [4:0]  i_addr_rd = '0;
  logic [31:0] i_data_rd = '0;
  logic        i_we_reg = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ce = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_flush = 1'b0;
  logic        wb_ack = 1'b0;
  logic        wb_stall = 1'b0;
  logic [31:0] wb_rdata = '0;

  // DUT outputs
  logic        o_stall, o_flush, o_ce;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_addr, wb_wdata;
  logic [3:0]  wb_sel;
  logic [6:0]  o_opcode;
  logic [2:0]  o_funct3;
  logic [4:0]  o_addr_rd;
  logic [31:0] o_data_rd;
  logic        o_we_reg, o_valid, o_misaligned;
  logic [1:0]  o_state;

  int total = 0;
  int bad = 0;

  logic [2:0] ld_f3 [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
  logic [2:0] st_f3 [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

  mem_access dut (
    .me_clk          (clk),
    .me_rst          (rst_n),
    .me_i_opcode     (i_opcode),
    .me_i_funct3     (i_funct3),
    .me_i_alu_value  (i_alu),
    .me_i_data_rs2   (i_rs2),
    .me_i_addr_rd    (i_addr_rd),
    .me_i_data_rd    (i_data_rd),
    .me_i_we_reg     (i_we_reg),
    .me_i_valid      (i_valid),
    .me_i_ce         (i_ce),
    .me_i_stall      (i_stall),
    .me_i_flush      (i_flush),
    .me_o_stall      (o_stall),
    .me_o_flush      (o_flush),
    .me_o_ce         (o_ce),
    .me_o_wb_cyc     (wb_cyc),
    .me_o_wb_stb     (wb_stb),
    .me_o_wb_we      (wb_we),
    .me_o_wb_addr    (wb_addr),
    .me_o_wb_data    (wb_wdata),
    .me_o_wb_sel     (wb_sel),
    .me_i_wb_ack     (wb_ack),
    .me_i_wb_stall   (wb_stall),
    .me_i_wb_data    (wb_rdata),
    .me_o_opcode     (o_opcode),
    .me_o_funct3     (o_funct3),
    .me_o_addr_rd    (o_addr_rd),
    .me_o_data_rd    (o_data_rd),
    .me_o_we_reg     (o_we_reg),
    .me_o_valid      (o_valid),
    .me_o_misaligned (o_misaligned),
    .me_o_dbg_state  (o_state)
  );

  // ---------------- reference model ----------------
  function automatic int nbytes(input bit st, input logic [2:0] f3);
    if (st) begin
      if (f3 == 3'd0) return 1;
      if (f3 == 3'd1) return 2;
      return 4;
    end
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] rdata, input int lane);
    logic [31:0] v;
    int n;
    n = nbytes(1'b0, f3);
    v = rdata >> (8 * lane);
    if (n == 1) begin
      v = v & 32'hFF;
      if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (n == 2) begin
      v = v & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // ---------------- driver helpers ----------------
  task automatic idle_inputs();
    i_ce = 1'b0;
    i_valid = 1'b0;
    i_we_reg = 1'b0;
    i_opcode = OPC_OP;
    i_funct3 = 3'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Non-memory instruction through the stage.
  task automatic run_alu(input string name, input logic [31:0] data, input bit we, input bit vin);
    logic [4:0] rd;
    logic [2:0] f3;
    rd = 5'($urandom_range(0, 31));
    f3 = 3'($urandom_range(0, 7));
    i_opcode = OPC_OP; i_funct3 = f3; i_alu = $urandom; i_addr_rd = rd;
    i_data_rd = data; i_we_reg = we; i_valid = vin; i_ce = 1'b1;
    tick();
    idle_inputs();
    total++; if (o_valid !== vin) begin bad++; $display("FAIL %s valid got=%0b want=%0b", name, o_valid, vin); end
    total++; if (o_we_reg !== we) begin bad++; $display("FAIL %s we_reg got=%0b want=%0b", name, o_we_reg, we); end
    total++; if (o_data_rd !== data) begin bad++; $display("FAIL %s data_rd got=%h want=%h", name, o_data_rd, data); end
    total++; if (o_addr_rd !== rd) begin bad++; $display("FAIL %s addr_rd got=%0d want=%0d", name, o_addr_rd, rd); end
    total++; if (o_opcode !== OPC_OP || o_funct3 !== f3) begin bad++; $display("FAIL %s opcode/funct3 got=%h/%0d want=%h/%0d", name, o_opcode, o_funct3, OPC_OP, f3); end
    total++; if (o_stall !== 1'b0 || wb_cyc !== 1'b0) begin bad++; $display("FAIL %s stall/cyc got=%0b/%0b want=0/0", name, o_stall, wb_cyc); end
    total++; if (o_ce !== 1'b1) begin bad++; $display("FAIL %s o_ce got=%0b want=1", name, o_ce); end
    tick();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL %s valid_pulse got=%0b want=0", name, o_valid); end
  endtask

  // One load/store with a scripted bus slave: wb_stall held n_stall edges,
  // ack ack_delay edges after the request is taken, optional flush in WAIT.
  task automatic run_mem(input string name, input bit st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                         input int n_stall, input int ack_delay, input bit flush);
    int n, lane, stall_cnt;
    bit mis, e_valid;
    logic [3:0] e_sel;
    logic [31:0] e_wdata, e_addr, e_data;
    logic [4:0] rd;
    n = nbytes(st, f3);
    lane = int'(addr[1:0]);
    mis = (addr % n) != 0;
    e_sel = st ? 4'(((1 << n) - 1) << lane) : 4'hF;
    if (n == 1) e_wdata = (rs2 & 32'hFF) * 32'h01010101;
    else if (n == 2) e_wdata = (rs2 & 32'hFFFF) * 32'h00010001;
    else e_wdata = rs2;
    e_addr = addr - (addr % 4);
    e_data = model_load(f3, rdata, lane);
    e_valid = !flush;
    rd = 5'($urandom_range(1, 31));

    i_opcode = st ? OPC_STORE : OPC_LOAD; i_funct3 = f3; i_alu = addr; i_rs2 = rs2;
    i_addr_rd = rd; i_data_rd = $urandom; i_we_reg = !st; i_valid = 1'b1; i_ce = 1'b1;
    tick();
    idle_inputs();

    if (mis) begin
      total++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin bad++; $display("FAIL %s mis_cyc got=%0b want=0", name, wb_cyc); end
      total++; if (o_misaligned !== 1'b1) begin bad++; $display("FAIL %s misaligned got=%0b want=1", name, o_misaligned); end
      total++; if (o_valid !== 1'b1 || o_we_reg !== 1'b0) begin bad++; $display("FAIL %s mis_valid/we got=%0b/%0b want=1/0", name, o_valid, o_we_reg); end
      total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL %s mis_stall got=%0b want=0", name, o_stall); end
      total++; if (o_addr_rd !== rd) begin bad++; $display("FAIL %s mis_addr_rd got=%0d want=%0d", name, o_addr_rd, rd); end
      tick();
      total++; if (o_valid !== 1'b0 || o_misaligned !== 1'b0 || o_stall !== 1'b0) begin bad++; $display("FAIL %s mis_pulse got=v%0b m%0b s%0b want=0", name, o_valid, o_misaligned, o_stall); end
      return;
    end

    total++; if (wb_cyc !== 1'b1 || wb_stb !== 1'b1) begin bad++; $display("FAIL %s req cyc/stb got=%0b/%0b want=1/1", name, wb_cyc, wb_stb); end
    total++; if (wb_we !== st) begin bad++; $display("FAIL %s we got=%0b want=%0b", name, wb_we, st); end
    total++; if (wb_addr !== e_addr) begin bad++; $display("FAIL %s addr got=%h want=%h", name, wb_addr, e_addr); end
    total++; if (wb_sel !== e_sel) begin bad++; $display("FAIL %s sel got=%b want=%b", name, wb_sel, e_sel); end
    if (st) begin
      total++; if (wb_wdata !== e_wdata) begin bad++; $display("FAIL %s wdata got=%h want=%h", name, wb_wdata, e_wdata); end
    end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL %s valid_in_req got=%0b want=0", name, o_valid); end
    stall_cnt = o_stall ? 1 : 0;

    for (int i = 0; i < n_stall; i++) begin
      wb_stall = 1'b1;
      tick();
      total++; if (wb_stb !== 1'b1 || wb_addr !== e_addr) begin bad++; $display("FAIL %s stb_hold got=%0b/%h want=1/%h", name, wb_stb, wb_addr, e_addr); end
      if (o_stall) stall_cnt++;
    end
    wb_stall = 1'b0;
    if (ack_delay == 0) begin wb_ack = 1'b1; wb_rdata = rdata; end
    tick();
    wb_ack = 1'b0;

    if (ack_delay > 0) begin
      total++; if (wb_stb !== 1'b0 || wb_cyc !== 1'b1) begin bad++; $display("FAIL %s wait stb/cyc got=%0b/%0b want=0/1", name, wb_stb, wb_cyc); end
      if (o_stall) stall_cnt++;
      for (int k = 1; k <= ack_delay; k++) begin
        if (flush && k == 1) i_flush = 1'b1;
        if (k == ack_delay) begin wb_ack = 1'b1; wb_rdata = rdata; end
        tick();
        if (flush && k == 1) begin
          total++; if (o_flush !== 1'b1) begin bad++; $display("FAIL %s o_flush got=%0b want=1", name, o_flush); end
        end
        i_flush = 1'b0;
        wb_ack = 1'b0;
        if (k < ack_delay) begin
          if (o_stall) stall_cnt++;
          total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL %s valid_in_wait got=%0b want=0", name, o_valid); end
        end
      end
    end

    total++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin bad++; $display("FAIL %s done cyc/stb got=%0b/%0b want=0/0", name, wb_cyc, wb_stb); end
    total++; if (o_stall !== 1'b0 || o_state !== 2'd0) begin bad++; $display("FAIL %s done stall/state got=%0b/%0d want=0/0", name, o_stall, o_state); end
    total++; if (o_valid !== e_valid) begin bad++; $display("FAIL %s done valid got=%0b want=%0b", name, o_valid, e_valid); end
    total++; if (o_we_reg !== (e_valid && !st)) begin bad++; $display("FAIL %s done we_reg got=%0b want=%0b", name, o_we_reg, e_valid && !st); end
    if (e_valid && !st) begin
      total++; if (o_data_rd !== e_data) begin bad++; $display("FAIL %s load data got=%h want=%h", name, o_data_rd, e_data); end
    end
    if (e_valid) begin
      total++; if (o_addr_rd !== rd) begin bad++; $display("FAIL %s done addr_rd got=%0d want=%0d", name, o_addr_rd, rd); end
    end
    total++; if (stall_cnt != 1 + n_stall + ack_delay) begin bad++; $display("FAIL %s stall cycles got=%0d want=%0d", name, stall_cnt, 1 + n_stall + ack_delay); end
    tick();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL %s valid_pulse got=%0b want=0", name, o_valid); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    total++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || wb_we !== 1'b0) begin bad++; $display("FAIL reset bus got=%0b%0b%0b want=000", wb_cyc, wb_stb, wb_we); end
    total++; if (wb_addr !== 32'd0 || wb_sel !== 4'd0 || wb_wdata !== 32'd0) begin bad++; $display("FAIL reset bus_data got=%h/%b/%h want=0", wb_addr, wb_sel, wb_wdata); end
    total++; if (o_valid !== 1'b0 || o_we_reg !== 1'b0 || o_misaligned !== 1'b0) begin bad++; $display("FAIL reset result_flags got=%0b%0b%0b want=000", o_valid, o_we_reg, o_misaligned); end
    total++; if (o_data_rd !== 32'd0 || o_addr_rd !== 5'd0) begin bad++; $display("FAIL reset result_data got=%h/%0d want=0", o_data_rd, o_addr_rd); end
    total++; if (o_stall !== 1'b0 || o_ce !== 1'b0 || o_flush !== 1'b0 || o_state !== 2'd0) begin bad++; $display("FAIL reset ctrl got=%0b%0b%0b/%0d want=0", o_stall, o_ce, o_flush, o_state); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stores();
    run_mem("sw_0x100", 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2, 1'b0);
    run_mem("sb_0x103", 1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0, 1, 1'b0);
    run_mem("sh_0x102", 1'b1, 3'd1, 32'h102, 32'h1234CAFE, 32'h0, 0, 0, 1'b0);
  endtask

  task automatic test_loads();
    run_mem("lb_0x202",  1'b0, 3'd0, 32'h202, 32'h0, 32'h80FF7F01, 0, 1, 1'b0);
    run_mem("lbu_0x203", 1'b0, 3'd4, 32'h203, 32'h0, 32'h80FF7F01, 0, 0, 1'b0);
    run_mem("lh_0x200",  1'b0, 3'd1, 32'h200, 32'h0, 32'h80FF7F01, 0, 2, 1'b0);
    run_mem("lhu_0x202", 1'b0, 3'd5, 32'h202, 32'h0, 32'h80FF7F01, 0, 1, 1'b0);
    run_mem("lw_0x204",  1'b0, 3'd2, 32'h204, 32'h0, 32'h80FF7F01, 0, 1, 1'b0);
  endtask

  task automatic test_wb_stall();
    run_mem("lw_wbstall", 1'b0, 3'd2, 32'h400, 32'h0, 32'h13579BDF, 3, 1, 1'b0);
    run_mem("sh_wbstall_ack_in_req", 1'b1, 3'd1, 32'h402, 32'h0000BEEF, 32'h0, 3, 0, 1'b0);
  endtask

  task automatic test_misaligned();
    run_mem("lw_mis_0x102", 1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 0, 1'b0);
    run_mem("sh_mis_0x101", 1'b1, 3'd1, 32'h101, 32'hFFFF, 32'h0, 0, 0, 1'b0);
  endtask

  task automatic test_flush();
    run_mem("lw_flush_wait", 1'b0, 3'd2, 32'h500, 32'h0, 32'hAAAA5555, 0, 2, 1'b1);
    run_mem("sw_flush_wait", 1'b1, 3'd2, 32'h504, 32'h01020304, 32'h0, 1, 1, 1'b1);
    // flush while idle with a valid result presented
    i_opcode = OPC_OP; i_data_rd = 32'h77; i_we_reg = 1'b1; i_valid = 1'b1; i_ce = 1'b1; i_addr_rd = 5'd9;
    tick();
    idle_inputs();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    total++; if (o_valid !== 1'b0 || o_we_reg !== 1'b0 || o_data_rd !== 32'd0) begin bad++; $display("FAIL flush_idle got=v%0b w%0b d%h want=0", o_valid, o_we_reg, o_data_rd); end
    total++; if (o_flush !== 1'b1 || o_ce !== 1'b0) begin bad++; $display("FAIL flush_idle flush/ce got=%0b/%0b want=1/0", o_flush, o_ce); end
  endtask

  task automatic test_hold();
    i_opcode = OPC_OP; i_funct3 = 3'd0; i_data_rd = 32'h1234; i_we_reg = 1'b1; i_valid = 1'b1; i_ce = 1'b1; i_addr_rd = 5'd5;
    tick();
    i_stall = 1'b1; i_data_rd = 32'h9999; i_addr_rd = 5'd7; i_funct3 = 3'd3;
    tick();
    tick();
    total++; if (o_valid !== 1'b1 || o_we_reg !== 1'b1) begin bad++; $display("FAIL hold valid/we got=%0b/%0b want=1/1", o_valid, o_we_reg); end
    total++; if (o_data_rd !== 32'h1234 || o_addr_rd !== 5'd5 || o_funct3 !== 3'd0) begin bad++; $display("FAIL hold data got=%h/%0d/%0d want=1234/5/0", o_data_rd, o_addr_rd, o_funct3); end
    i_stall = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    i_opcode = OPC_LOAD; i_funct3 = 3'd2; i_alu = 32'h300; i_valid = 1'b1; i_ce = 1'b1; i_addr_rd = 5'd3;
    wb_stall = 1'b1;
    tick();
    idle_inputs();
    total++; if (wb_cyc !== 1'b1) begin bad++; $display("FAIL rst_mid started cyc got=%0b want=1", wb_cyc); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin bad++; $display("FAIL rst_mid cyc/stb got=%0b/%0b want=0/0", wb_cyc, wb_stb); end
    total++; if (o_stall !== 1'b0 || o_state !== 2'd0 || wb_addr !== 32'd0 || o_valid !== 1'b0) begin bad++; $display("FAIL rst_mid outs got=s%0b st%0d a%h v%0b want=0", o_stall, o_state, wb_addr, o_valid); end
    wb_stall = 1'b0;
    tick();
    rst_n = 1'b1;
    wb_ack = 1'b1; wb_rdata = 32'hFFFFFFFF;
    tick();
    wb_ack = 1'b0;
    total++; if (o_valid !== 1'b0 || wb_cyc !== 1'b0 || o_state !== 2'd0) begin bad++; $display("FAIL rst_mid stale_ack got=v%0b c%0b st%0d want=0", o_valid, wb_cyc, o_state); end
    run_mem("lw_after_rst", 1'b0, 3'd2, 32'h308, 32'h0, 32'h0BADF00D, 0, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int kind, n, ns, ad;
      bit st, fl;
      logic [2:0] f3;
      logic [31:0] addr;
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        run_alu("rand_alu", $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        st = (kind == 3);
        f3 = st ? st_f3[$urandom_range(0, 5)] : ld_f3[$urandom_range(0, 7)];
        n = nbytes(st, f3);
        addr = $urandom;
        if ($urandom_range(0, 3) != 0) addr = addr - (addr % n);
        ns = $urandom_range(0, 3);
        ad = $urandom_range(0, 3);
        fl = (ad > 0) && ($urandom_range(0, 4) == 0);
        run_mem("rand_mem", st, f3, addr, $urandom, $urandom, ns, ad, fl);
      end
    end
  endtask

  initial begin
    test_reset();
    run_alu("add_0x1234", 32'h1234, 1'b1, 1'b1);
    test_stores();
    test_loads();
    test_wb_stall();
    test_misaligned();
    test_flush();
    test_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
